// File: rtl/vc_flit_buffer_pkg.sv
// Shared types for the multi-VC router input flit buffer: flit type, per-VC
// buffer state encoding and the default build constants.
package types;

  localparam int FLIT_WIDTH_DEF = 64;
  localparam int DEPTH_DEF      = 4;
  localparam int NUM_VC_DEF     = 2;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    VACANT      = 2'd1,
    ALMOST_FULL = 2'd2,
    FULL        = 2'd3
  } buffer_state_t;

  // VC select width; a single-channel build still carries a 1-bit select.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/vc_flit_buffer_if.sv
// Push/pop request bus and per-VC status bus of the VC flit buffer.
// master drives requests and observes status; slave is the buffer itself.
interface vc_flit_buffer_if
  import types::*;
#(
  parameter int FLIT_WIDTH = $bits(flit_t),
  parameter int DEPTH      = DEPTH_DEF,
  parameter int NUM_VC     = NUM_VC_DEF
);

  localparam int VC_W  = vc_width(NUM_VC);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         push_valid;
  logic [VC_W-1:0]              push_vc;
  logic [FLIT_WIDTH-1:0]        push_flit;
  logic                         pop_valid;
  logic [VC_W-1:0]              pop_vc;
  logic [NUM_VC*FLIT_WIDTH-1:0] head_flit;
  logic [NUM_VC*CNT_W-1:0]      count;
  logic [NUM_VC*2-1:0]          state;
  logic [NUM_VC-1:0]            err;

  modport master (
    output push_valid, push_vc, push_flit, pop_valid, pop_vc,
    input  head_flit, count, state, err
  );

  modport slave (
    input  push_valid, push_vc, push_flit, pop_valid, pop_vc,
    output head_flit, count, state, err
  );

endinterface

// File: rtl/vc_flit_buffer_flit_fifo_ch.sv
// Single virtual-channel circular FIFO: storage, pointers, occupancy, state
// decode and the sticky error flag (built only with VC_FLIT_BUFFER_ERR_EN).
module flit_fifo_ch
  import types::*;
#(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int AF_TH      = DEPTH - 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_req,
  input  logic                  push_en,
  input  logic                  pop_req,
  input  logic                  pop_en,
  input  logic [FLIT_WIDTH-1:0] push_flit,
  output logic [FLIT_WIDTH-1:0] head_flit,
  output logic [CNT_W-1:0]      count,
  output buffer_state_t         state,
  output logic                  err
);

  logic [FLIT_WIDTH-1:0] storage_q [DEPTH];
  logic [FLIT_WIDTH-1:0] storage_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // On a full channel push and pop share a slot: wr_ptr equals rd_ptr, so the
  // incoming flit overwrites exactly the entry being consumed.
  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_en) begin
      storage_d[wr_ptr_q] = push_flit;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the empty mask on head_flit hides stale data.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

  always_comb begin
    if (count_q == '0)
      state = EMPTY;
    else if (count_q == CNT_W'(DEPTH))
      state = FULL;
    else if (count_q >= CNT_W'(AF_TH))
      state = ALMOST_FULL;
    else
      state = VACANT;
  end

  assign head_flit = (count_q != '0) ? storage_q[rd_ptr_q] : '0;
  assign count     = count_q;

`ifdef VC_FLIT_BUFFER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (push_req & ~push_en) | (pop_req & ~pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_req;
  assign unused_req = push_req ^ pop_req;
  assign err        = 1'b0;
`endif

  logic [PTR_W-1:0] ptr_diff;
  assign ptr_diff = wr_ptr_q - rd_ptr_q;

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));
  a_state_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == EMPTY) == (count_q == '0)) &&
    ((state == FULL) == (count_q == CNT_W'(DEPTH))));
  a_ptr_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_diff == count_q[PTR_W-1:0]);

endmodule

// File: rtl/vc_flit_buffer.sv
// Multi-VC flit buffer for a router input port: decodes the single push and
// pop request onto per-VC FIFOs. Optional error flags: VC_FLIT_BUFFER_ERR_EN.
module vc_flit_buffer
  import types::*;
#(
  parameter int FLIT_WIDTH = $bits(flit_t),
  parameter int DEPTH      = DEPTH_DEF,
  parameter int NUM_VC     = NUM_VC_DEF,
  parameter int AF_TH      = DEPTH - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vc_flit_buffer_if.slave   bus
);

  localparam int VC_W  = vc_width(NUM_VC);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("vc_flit_buffer: DEPTH must be a power of two and at least 2");
  end
  if ((AF_TH < 1) || (AF_TH >= DEPTH)) begin : g_bad_af_th
    $error("vc_flit_buffer: AF_TH must satisfy 1 <= AF_TH < DEPTH");
  end

  logic [NUM_VC-1:0]     push_req;
  logic [NUM_VC-1:0]     push_en;
  logic [NUM_VC-1:0]     pop_req;
  logic [NUM_VC-1:0]     pop_en;
  logic [CNT_W-1:0]      count_ch [NUM_VC];
  logic [FLIT_WIDTH-1:0] head_ch  [NUM_VC];
  buffer_state_t         state_ch [NUM_VC];
  logic [NUM_VC-1:0]     err_ch;

  // Select values beyond NUM_VC-1 match no channel and are simply dropped.
  always_comb begin
    push_req = '0;
    push_en  = '0;
    pop_req  = '0;
    pop_en   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_req[v] = bus.push_valid && (bus.push_vc == VC_W'(v));
      pop_req[v]  = bus.pop_valid && (bus.pop_vc == VC_W'(v));
      pop_en[v]   = pop_req[v] && (count_ch[v] != '0);
      push_en[v]  = push_req[v] && ((count_ch[v] != CNT_W'(DEPTH)) || pop_en[v]);
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    flit_fifo_ch #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (DEPTH),
      .AF_TH      (AF_TH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_req   (push_req[v]),
      .push_en    (push_en[v]),
      .pop_req    (pop_req[v]),
      .pop_en     (pop_en[v]),
      .push_flit  (bus.push_flit),
      .head_flit  (head_ch[v]),
      .count      (count_ch[v]),
      .state      (state_ch[v]),
      .err        (err_ch[v])
    );

    assign bus.head_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = head_ch[v];
    assign bus.count[v*CNT_W +: CNT_W]               = count_ch[v];
    assign bus.state[v*2 +: 2]                       = state_ch[v];
  end

  assign bus.err = err_ch;

endmodule

// File: tb/tb_vc_flit_buffer.sv
// Directed bench for vc_flit_buffer (DEPTH=4, NUM_VC=2, AF_TH=3): a vector
// table for the single-cycle behaviour plus reset and latency sequences.
module tb_vc_flit_buffer;

  localparam int FW = 64;
  localparam logic [1:0] EM = 2'd0, VA = 2'd1, AF = 2'd2, FU = 2'd3;
`ifdef VC_FLIT_BUFFER_ERR_EN
  localparam logic [1:0] E1 = 2'b10, E01 = 2'b11;
`else
  localparam logic [1:0] E1 = 2'b00, E01 = 2'b00;
`endif

  typedef struct {
    logic          pv;
    logic          pvc;
    logic [FW-1:0] pf;
    logic          ov;
    logic          ovc;
    logic [2:0]    c0, c1;
    logic [FW-1:0] h0, h1;
    logic [1:0]    s0, s1;
    logic [1:0]    e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vc_flit_buffer_if #(.FLIT_WIDTH(FW), .DEPTH(4), .NUM_VC(2)) bus ();

  vc_flit_buffer #(.FLIT_WIDTH(FW), .DEPTH(4), .NUM_VC(2), .AF_TH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [2:0] c0,
                           input logic [2:0] c1, input logic [FW-1:0] h0,
                           input logic [FW-1:0] h1, input logic [1:0] s0,
                           input logic [1:0] s1, input logic [1:0] e);
    chk({tag, "_count"}, idx, 128'(bus.count), 128'({c1, c0}));
    chk({tag, "_head"},  idx, 128'(bus.head_flit), {h1, h0});
    chk({tag, "_state"}, idx, 128'(bus.state), 128'({s1, s0}));
    chk({tag, "_err"},   idx, 128'(bus.err), 128'(e));
  endtask

  function automatic void add(input logic pv, input logic pvc, input logic [FW-1:0] pf,
                              input logic ov, input logic ovc, input logic [2:0] c0,
                              input logic [2:0] c1, input logic [FW-1:0] h0,
                              input logic [FW-1:0] h1, input logic [1:0] s0,
                              input logic [1:0] s1, input logic [1:0] e);
    vec_t t;
    t.pv = pv; t.pvc = pvc; t.pf = pf; t.ov = ov; t.ovc = ovc;
    t.c0 = c0; t.c1 = c1; t.h0 = h0; t.h1 = h1; t.s0 = s0; t.s1 = s1; t.e = e;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic pv, input logic pvc, input logic [FW-1:0] pf,
                       input logic ov, input logic ovc);
    bus.push_valid = pv;
    bus.push_vc    = pvc;
    bus.push_flit  = pf;
    bus.pop_valid  = ov;
    bus.pop_vc     = ovc;
  endtask

  initial begin
    // Fill VC1 to full, overflow, drain, underflow on both VCs.
    add(1, 1, 64'hA1, 0, 0, 0, 1, 0, 64'hA1, EM, VA, 0);
    add(1, 1, 64'hA2, 0, 0, 0, 2, 0, 64'hA1, EM, VA, 0);
    add(1, 1, 64'hA3, 0, 0, 0, 3, 0, 64'hA1, EM, AF, 0);
    add(1, 1, 64'hA4, 0, 0, 0, 4, 0, 64'hA1, EM, FU, 0);
    add(1, 1, 64'hA5, 0, 0, 0, 4, 0, 64'hA1, EM, FU, E1);
    add(0, 0, 64'h0,  1, 1, 0, 3, 0, 64'hA2, EM, AF, E1);
    add(0, 0, 64'h0,  1, 1, 0, 2, 0, 64'hA3, EM, VA, E1);
    add(0, 0, 64'h0,  1, 1, 0, 1, 0, 64'hA4, EM, VA, E1);
    add(0, 0, 64'h0,  1, 1, 0, 0, 0, 64'h0,  EM, EM, E1);
    add(0, 0, 64'h0,  1, 1, 0, 0, 0, 64'h0,  EM, EM, E1);
    add(0, 0, 64'h0,  1, 0, 0, 0, 0, 64'h0,  EM, EM, E01);
    // Six push/pop alternations on VC0: pointers wrap past DEPTH-1.
    for (int k = 0; k < 6; k++) begin
      add(1, 0, 64'h10 + 64'(k), 0, 0, 1, 0, 64'h10 + 64'(k), 0, VA, EM, E01);
      add(0, 0, 64'h0, 1, 0, 0, 0, 0, 0, EM, EM, E01);
    end
    add(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, EM, EM, E01);
    // Full VC0: simultaneous push+pop keeps count at DEPTH.
    add(1, 0, 64'h20, 0, 0, 1, 0, 64'h20, 0, VA, EM, E01);
    add(1, 0, 64'h21, 0, 0, 2, 0, 64'h20, 0, VA, EM, E01);
    add(1, 0, 64'h22, 0, 0, 3, 0, 64'h20, 0, AF, EM, E01);
    add(1, 0, 64'h23, 0, 0, 4, 0, 64'h20, 0, FU, EM, E01);
    add(1, 0, 64'hB0, 1, 0, 4, 0, 64'h21, 0, FU, EM, E01);
    add(0, 0, 64'h0,  1, 0, 3, 0, 64'h22, 0, AF, EM, E01);
    add(0, 0, 64'h0,  1, 0, 2, 0, 64'h23, 0, VA, EM, E01);
    add(0, 0, 64'h0,  1, 0, 1, 0, 64'hB0, 0, VA, EM, E01);
    add(0, 0, 64'h0,  1, 0, 0, 0, 64'h0,  0, EM, EM, E01);
    // Empty VC0: push accepted, pop rejected.
    add(1, 0, 64'hB0, 1, 0, 1, 0, 64'hB0, 0, VA, EM, E01);
    // Different VCs on the same edge, then same-VC push+pop at count 1.
    add(1, 1, 64'hC0, 1, 0, 0, 1, 64'h0, 64'hC0, EM, VA, E01);
    add(1, 1, 64'hD0, 1, 1, 0, 1, 64'h0, 64'hD0, EM, VA, E01);

    drive(0, 0, '0, 0, 0);
    #3 rst_n = 1'b0;
    #1 check_all("reset", 0, 0, 0, 0, 0, EM, EM, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].pv, tbl[i].pvc, tbl[i].pf, tbl[i].ov, tbl[i].ovc);
      @(posedge clk);
      #1 check_all("vec", i, tbl[i].c0, tbl[i].c1, tbl[i].h0, tbl[i].h1,
                   tbl[i].s0, tbl[i].s1, tbl[i].e);
    end

    // Asynchronous reset with three flits held in VC0, away from any edge.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 0, 64'h30 + 64'(k), 0, 0);
      @(posedge clk);
    end
    #1 drive(0, 0, '0, 0, 0);
    check_all("pre_rst", 0, 3, 1, 64'h30, 64'hD0, AF, VA, E01);
    #2 rst_n = 1'b0;
    #1 check_all("mid_rst", 0, 0, 0, 0, 0, EM, EM, 0);
    @(negedge clk) rst_n = 1'b1;

    // Write-to-read latency: nothing visible before the sampling edge.
    @(negedge clk);
    drive(1, 0, 64'h55, 0, 0);
    #1 check_all("no_bypass", 0, 0, 0, 0, 0, EM, EM, 0);
    @(posedge clk);
    #1 check_all("latency", 0, 1, 0, 64'h55, 0, VA, EM, 0);
    drive(0, 0, '0, 0, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
